// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM slice.
//   rd_mode_t   per-port read-during-write behaviour
//   ST_INIT     zero-fill sweep in progress
//   ST_RUN      normal port access
package ram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rd_mode_t;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/dual_port_ram_sync_be_if.sv
// One RAM access port. The RAM is instantiated with two of these.
//   en    access enable
//   we    write (qualified by en)
//   be    byte enables (qualified by we)
//   addr  word address
//   din   write data
//   dout  registered read data
//   vld   dout carries the result of an access issued RD_LAT cycles earlier
interface dual_port_ram_sync_be_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    localparam int BE_W = DATA_W / 8;

    logic              en;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              vld;

    modport master (output en, we, be, addr, din, input dout, vld);
    modport slave  (input en, we, be, addr, din, output dout, vld);

endinterface

// File: rtl/ram_rd_pipe.sv
// Read-data/valid register chain, RD_LAT (1 or 2) stages deep.
// Data registers only load when a valid access passes through, so the output
// holds its last value between accesses. rst clears every stage.
//   clk, rst   clock, synchronous active-high clear
//   in_vld     an access was accepted this cycle
//   in_data    word to return for that access
//   out_vld    result emerges
//   out_data   returned word (held when out_vld is low)
module ram_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);

    logic              s1_vld;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_vld <= in_vld;
            if (in_vld) s1_data <= in_data;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_vld;
            logic [DATA_W-1:0] s2_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_vld  <= 1'b0;
                    s2_data <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) s2_data <= s1_data;
                end
            end

            assign out_vld  = s2_vld;
            assign out_data = s2_data;
        end else begin : g_lat1
            assign out_vld  = s1_vld;
            assign out_data = s1_data;
        end
    endgenerate

endmodule

// File: rtl/dual_port_ram_sync_be.sv
// True dual-port RAM, single clock, byte write enables, registered reads.
// Optional zero-fill sweep after every reset.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   port_a     access port A (wins overlapping byte lanes on same-address writes)
//   port_b     access port B
//   init_busy  zero-fill sweep running; all port accesses are ignored
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_INIT | writing 0 to mem[cnt], cnt 0 .. DEPTH-1
//   ST_RUN  | ports A and B access the array
module dual_port_ram_sync_be
    import ram_pkg::*;
#(
    parameter int       DATA_W    = 8,
    parameter int       ADDR_W    = 6,
    parameter int       BE_W      = DATA_W / 8,
    parameter int       RD_LAT    = 1,
    parameter rd_mode_t MODE_A    = READ_FIRST,
    parameter rd_mode_t MODE_B    = READ_FIRST,
    parameter bit       INIT_ZERO = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    dual_port_ram_sync_be_if.slave   port_a,
    dual_port_ram_sync_be_if.slave   port_b,
    output logic                     init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;

    logic              acc_a, acc_b;
    logic              wr_a, wr_b;
    logic [DATA_W-1:0] old_a, old_b;
    logic [DATA_W-1:0] merged_a, merged_b;
    logic [DATA_W-1:0] rd_a, rd_b;

    // Accesses presented while rst is high are dropped along with the pipeline.
    assign acc_a = port_a.en && (state == ST_RUN) && !rst;
    assign acc_b = port_b.en && (state == ST_RUN) && !rst;
    assign wr_a  = acc_a && port_a.we;
    assign wr_b  = acc_b && port_b.we;

    assign old_a = mem[port_a.addr];
    assign old_b = mem[port_b.addr];

    // Each port's own view of its write; the other port's write is never visible
    // in the same cycle, so a cross-port reader always sees the old word.
    always_comb begin
        merged_a = old_a;
        for (int i = 0; i < BE_W; i++)
            if (port_a.be[i]) merged_a[8*i +: 8] = port_a.din[8*i +: 8];
    end

    always_comb begin
        merged_b = old_b;
        for (int i = 0; i < BE_W; i++)
            if (port_b.be[i]) merged_b[8*i +: 8] = port_b.din[8*i +: 8];
    end

    assign rd_a = (MODE_A == WRITE_FIRST && wr_a) ? merged_a : old_a;
    assign rd_b = (MODE_B == WRITE_FIRST && wr_b) ? merged_b : old_b;

    // Port A lane writes are issued after port B's, so A overrides B on
    // overlapping lanes at the same address.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_INIT) begin
            mem[cnt] <= '0;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_b && port_b.be[i]) mem[port_b.addr][8*i +: 8] <= port_b.din[8*i +: 8];
                if (wr_a && port_a.be[i]) mem[port_a.addr][8*i +: 8] <= port_a.din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT_ZERO ? ST_INIT : ST_RUN;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == ADDR_W'(DEPTH - 1)) state <= ST_RUN;
        end
    end

    assign init_busy = (state == ST_INIT);

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_pipe_a (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (acc_a),
        .in_data  (rd_a),
        .out_vld  (port_a.vld),
        .out_data (port_a.dout)
    );

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_pipe_b (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (acc_b),
        .in_data  (rd_b),
        .out_vld  (port_b.vld),
        .out_data (port_b.dout)
    );

endmodule

// File: tb/tb_dual_port_ram_sync_be.sv
// Two RAM instances driven with identical stimulus:
//   u_dut1  RD_LAT=1, A WRITE_FIRST, B READ_FIRST
//   u_dut2  RD_LAT=2, A READ_FIRST,  B WRITE_FIRST
// Reference: word array plus a queue of expected results per port, each entry
// tagged with the cycle at which it should appear on dout.
module tb_dual_port_ram_sync_be;
    import ram_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          s_en   [2];
    logic          s_we   [2];
    logic [1:0]    s_be   [2];
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_din  [2];

    dual_port_ram_sync_be_if #(.DATA_W(DW), .ADDR_W(AW)) a1 ();
    dual_port_ram_sync_be_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
    dual_port_ram_sync_be_if #(.DATA_W(DW), .ADDR_W(AW)) a2 ();
    dual_port_ram_sync_be_if #(.DATA_W(DW), .ADDR_W(AW)) b2 ();

    assign a1.en = s_en[0];   assign a2.en = s_en[0];
    assign a1.we = s_we[0];   assign a2.we = s_we[0];
    assign a1.be = s_be[0];   assign a2.be = s_be[0];
    assign a1.addr = s_addr[0]; assign a2.addr = s_addr[0];
    assign a1.din = s_din[0]; assign a2.din = s_din[0];
    assign b1.en = s_en[1];   assign b2.en = s_en[1];
    assign b1.we = s_we[1];   assign b2.we = s_we[1];
    assign b1.be = s_be[1];   assign b2.be = s_be[1];
    assign b1.addr = s_addr[1]; assign b2.addr = s_addr[1];
    assign b1.din = s_din[1]; assign b2.din = s_din[1];

    logic busy1, busy2;

    dual_port_ram_sync_be #(
        .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1),
        .MODE_A(WRITE_FIRST), .MODE_B(READ_FIRST), .INIT_ZERO(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .port_a(a1), .port_b(b1), .init_busy(busy1)
    );

    dual_port_ram_sync_be #(
        .DATA_W(DW), .ADDR_W(AW), .RD_LAT(2),
        .MODE_A(READ_FIRST), .MODE_B(WRITE_FIRST), .INIT_ZERO(1'b1)
    ) u_dut2 (
        .clk(clk), .rst(rst), .port_a(a2), .port_b(b2), .init_busy(busy2)
    );

    // index k: 0=dut1 A, 1=dut1 B, 2=dut2 A, 3=dut2 B
    logic          obs_vld  [4];
    logic [DW-1:0] obs_dout [4];
    assign obs_vld[0] = a1.vld;  assign obs_dout[0] = a1.dout;
    assign obs_vld[1] = b1.vld;  assign obs_dout[1] = b1.dout;
    assign obs_vld[2] = a2.vld;  assign obs_dout[2] = a2.dout;
    assign obs_vld[3] = b2.vld;  assign obs_dout[3] = b2.dout;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          pend [4][$];
    logic [DW-1:0] exp_dout [4];
    logic [DW-1:0] ref_mem [DEPTH];
    int            init_left = 0;
    int            t = 0;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k < 2) ? 1 : 2;
    endfunction

    function automatic bit wf_of(input int k);
        return (k == 0) || (k == 3);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [1:0]    be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < 2; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // Called at a falling edge with inputs set: updates the model for the
    // coming rising edge, advances one cycle and compares all outputs.
    task automatic step();
        logic [DW-1:0] old_w [2];
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                pend[k].delete();
                exp_dout[k] = '0;
            end
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            init_left = DEPTH;
        end else if (init_left > 0) begin
            init_left--;
        end else begin
            for (int p = 0; p < 2; p++) old_w[p] = ref_mem[s_addr[p]];
            for (int p = 0; p < 2; p++) begin
                if (s_en[p]) begin
                    for (int d = 0; d < 2; d++) begin
                        int   k;
                        ent_t e;
                        k      = d * 2 + p;
                        e.due  = t + lat_of(k);
                        e.data = (s_we[p] && wf_of(k)) ? merge(old_w[p], s_din[p], s_be[p]) : old_w[p];
                        pend[k].push_back(e);
                    end
                end
            end
            // B first, then A: A's lanes overwrite B's on a shared address
            for (int p = 1; p >= 0; p--)
                if (s_en[p] && s_we[p])
                    ref_mem[s_addr[p]] = merge(ref_mem[s_addr[p]], s_din[p], s_be[p]);
        end
        @(negedge clk);
        t++;
        chk("init_busy1", {31'd0, busy1}, {31'd0, init_left > 0});
        chk("init_busy2", {31'd0, busy2}, {31'd0, init_left > 0});
        for (int k = 0; k < 4; k++) begin
            logic ev;
            ev = 1'b0;
            if (pend[k].size() > 0 && pend[k][0].due == t) begin
                ent_t e;
                e = pend[k].pop_front();
                ev = 1'b1;
                exp_dout[k] = e.data;
            end
            chk($sformatf("vld%0d", k), {31'd0, obs_vld[k]}, {31'd0, ev});
            chk($sformatf("dout%0d", k), {16'd0, obs_dout[k]}, {16'd0, exp_dout[k]});
        end
    endtask

    task automatic set_port(input int p, input bit en, input bit we, input logic [1:0] be,
                            input logic [AW-1:0] addr, input logic [DW-1:0] din);
        s_en[p]   = en;
        s_we[p]   = we;
        s_be[p]   = be;
        s_addr[p] = addr;
        s_din[p]  = din;
    endtask

    task automatic idle();
        set_port(0, 1'b0, 1'b0, 2'b00, '0, '0);
        set_port(1, 1'b0, 1'b0, 2'b00, '0, '0);
    endtask

    task automatic rand_ports(input int amax);
        for (int p = 0; p < 2; p++)
            set_port(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), AW'($urandom_range(0, amax)), DW'($urandom));
    endtask

    task automatic settle();
        idle();
        step();
        step();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Random port activity throughout the sweep must be ignored.
    task automatic run_init(input string tag);
        int n;
        n = 0;
        do begin
            rand_ports(DEPTH - 1);
            step();
            n++;
        end while (busy1 && n < 200);
        idle();
        chk(tag, n, 64);
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset();
        run_init("t1_init_len");

        // 1: post-init read of the last word
        set_port(0, 1'b1, 1'b0, 2'b00, 6'h3F, '0);
        step();
        settle();
        chk("t1_rd3f_dut1", {16'd0, obs_dout[0]}, 32'h0);
        chk("t1_rd3f_dut2", {16'd0, obs_dout[2]}, 32'h0);

        // 2: write on A, read back on B
        set_port(0, 1'b1, 1'b1, 2'b11, 6'h03, 16'h00A5);
        step();
        idle();
        set_port(1, 1'b1, 1'b0, 2'b00, 6'h03, '0);
        step();
        settle();
        chk("t2_rd_b_dut1", {16'd0, obs_dout[1]}, 32'h00A5);
        chk("t2_rd_b_dut2", {16'd0, obs_dout[3]}, 32'h00A5);

        // 3: partial byte write preserves the other lane
        set_port(0, 1'b1, 1'b1, 2'b11, 6'h05, 16'h1234);
        step();
        set_port(0, 1'b1, 1'b1, 2'b10, 6'h05, 16'hABCD);
        step();
        set_port(0, 1'b1, 1'b0, 2'b00, 6'h05, '0);
        step();
        settle();
        chk("t3_merge_dut1", {16'd0, obs_dout[0]}, 32'hAB34);
        chk("t3_merge_dut2", {16'd0, obs_dout[2]}, 32'hAB34);

        // 4: A writes while B reads the same address
        set_port(0, 1'b1, 1'b1, 2'b11, 6'h07, 16'h0011);
        step();
        set_port(0, 1'b1, 1'b1, 2'b11, 6'h07, 16'h000B);
        set_port(1, 1'b1, 1'b0, 2'b00, 6'h07, '0);
        step();
        settle();
        chk("t4_wf_a_dut1", {16'd0, obs_dout[0]}, 32'h000B);
        chk("t4_rd_b_dut1", {16'd0, obs_dout[1]}, 32'h0011);
        chk("t4_rf_a_dut2", {16'd0, obs_dout[2]}, 32'h0011);
        chk("t4_rd_b_dut2", {16'd0, obs_dout[3]}, 32'h0011);

        // 5: both write the same address, A wins its lane
        set_port(0, 1'b1, 1'b1, 2'b01, 6'h0F, 16'h0013);
        set_port(1, 1'b1, 1'b1, 2'b11, 6'h0F, 16'h0077);
        step();
        idle();
        set_port(0, 1'b1, 1'b0, 2'b00, 6'h0F, '0);
        step();
        settle();
        chk("t5_collide_dut1", {16'd0, obs_dout[0]}, 32'h0013);
        chk("t5_collide_dut2", {16'd0, obs_dout[2]}, 32'h0013);

        // random traffic, small address window for frequent collisions
        for (int i = 0; i < 400; i++) begin
            rand_ports((i % 4 == 0) ? DEPTH - 1 : 7);
            step();
        end
        settle();

        // 6: reset mid-sweep restarts it
        do_reset();
        for (int i = 0; i < 20; i++) begin
            rand_ports(DEPTH - 1);
            step();
        end
        do_reset();
        run_init("t6_init_len");

        // 6: reset while reads are in flight
        set_port(0, 1'b1, 1'b1, 2'b11, 6'h10, 16'h5A5A);
        step();
        set_port(0, 1'b1, 1'b0, 2'b00, 6'h10, '0);
        set_port(1, 1'b1, 1'b0, 2'b00, 6'h10, '0);
        step();
        do_reset();
        chk("t6_drop_vld_a2", {31'd0, obs_vld[2]}, 32'h0);
        chk("t6_drop_vld_b2", {31'd0, obs_vld[3]}, 32'h0);
        chk("t6_dout_a2", {16'd0, obs_dout[2]}, 32'h0);
        chk("t6_dout_a1", {16'd0, obs_dout[0]}, 32'h0);
        run_init("t6b_init_len");

        for (int i = 0; i < 100; i++) begin
            rand_ports(7);
            step();
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
